// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern arbiter.
// Holds pattern codes, FSM states, the default tick period and the pattern lookup.
package led_pkg;

  typedef enum logic [1:0] {
    SOLID     = 2'd0,
    SLOW      = 2'd1,
    FAST      = 2'd2,
    HEARTBEAT = 2'd3
  } mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned TICK_DIV_DEFAULT = 32'd10000000;

  // LED level for a given pattern and window phase.
  function automatic logic led_pattern(input mode_t m, input logic [1:0] ph);
    case (m)
      SOLID:   return 1'b1;
      SLOW:    return ~ph[1];
      FAST:    return ~ph[0];
      default: return (ph == 2'd0);
    endcase
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Pattern tick divider: 32-bit count 0..TICK_DIV-1, one-cycle tick at the top count.
// clr restarts the count from zero so a new window always gets a full tick period.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam logic [31:0] LAST = 32'(TICK_DIV - 1);

  logic [31:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/led_arbiter.sv
// Grants one requester a 4-tick LED pattern window; one-cycle req->gnt, re-arbitration at window end.
// Winner policy: fixed lowest-index priority, or round-robin when LED_ARB_ROUND_ROBIN_EN is defined.
module led_arbiter
  import led_pkg::*;
#(
  parameter int          NREQ     = 4,
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] mode,
  output logic              led,
  output logic [NREQ-1:0]   gnt,
  output logic              busy
);

  localparam int IW = $clog2(NREQ);

  state_t          state, state_nxt;
  logic [1:0]      phase, phase_nxt;
  mode_t           mode_q, mode_nxt, win_mode;
  logic [NREQ-1:0] gnt_nxt, win_oh;
  logic            led_nxt, busy_nxt;
  logic [IW-1:0]   win_idx;
  logic            tick, any_req, dropped, window_end, do_grant;

  assign any_req    = |req;
  assign dropped    = (state == RUN) && ((req & gnt) == '0);
  assign window_end = (state == RUN) && tick && (phase == 2'd3);
  // A drop always beats the window-end re-arbitration.
  assign do_grant   = any_req && !dropped && ((state == IDLE) || window_end);

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (do_grant),
    .tick  (tick)
  );

`ifdef LED_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr;

  // Descending scan so the nearest index after ptr is written last and wins.
  always_comb begin
    win_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[IW'((int'(ptr) + k) % NREQ)]) begin
        win_idx = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= IW'(NREQ - 1);
    end else if (do_grant) begin
      ptr <= win_idx;
    end
  end
`else
  always_comb begin
    win_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        win_idx = IW'(k);
      end
    end
  end
`endif

  assign win_oh = NREQ'(1) << win_idx;

  always_comb begin
    win_mode = SOLID;
    for (int k = 0; k < NREQ; k++) begin
      if (win_idx == IW'(k)) begin
        win_mode = mode_t'(mode[2*k +: 2]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = RUN;
      RUN:     if (dropped || (window_end && !any_req)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_nxt   = gnt;
    led_nxt   = led;
    busy_nxt  = busy;
    phase_nxt = phase;
    mode_nxt  = mode_q;
    if (state_nxt == IDLE) begin
      gnt_nxt   = '0;
      led_nxt   = 1'b0;
      busy_nxt  = 1'b0;
      phase_nxt = 2'd0;
    end else if (do_grant) begin
      gnt_nxt   = win_oh;
      mode_nxt  = win_mode;
      phase_nxt = 2'd0;
      led_nxt   = led_pattern(win_mode, 2'd0);
      busy_nxt  = 1'b1;
    end else if (tick) begin
      phase_nxt = phase + 2'd1;
      led_nxt   = led_pattern(mode_q, phase + 2'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt    <= '0;
      led    <= 1'b0;
      busy   <= 1'b0;
      phase  <= 2'd0;
      mode_q <= SOLID;
    end else begin
      gnt    <= gnt_nxt;
      led    <= led_nxt;
      busy   <= busy_nxt;
      phase  <= phase_nxt;
      mode_q <= mode_nxt;
    end
  end

endmodule

// File: tb/tb_led_arbiter.sv
// Bench for led_arbiter: window-timing reference model compared every cycle, plus directed literal checks.
module tb_led_arbiter;

  localparam int NREQ = 4;
  localparam int TD   = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req   = 4'b0;
  logic [7:0] mode  = 8'b0;
  logic       led;
  logic [3:0] gnt;
  logic       busy;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  led_arbiter #(.NREQ(NREQ), .TICK_DIV(TD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .mode  (mode),
    .led   (led),
    .gnt   (gnt),
    .busy  (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Reference model: a window owner, the edge at which it was granted and its latched mode.
  bit         m_run   = 1'b0;
  int         m_owner = 0;
  int         m_start = 0;
  int         m_ptr   = NREQ - 1;
  int         n       = 0;
  logic [1:0] m_mode  = 2'b0;
  int         w;

  function automatic int pick(input logic [3:0] r, input int p);
    int idx;
`ifdef LED_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= NREQ; k++) begin
      idx = (p + k) % NREQ;
      if (r[idx[1:0]]) return idx;
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      idx = k;
      if (r[idx[1:0]]) return idx;
    end
`endif
    return -1;
  endfunction

  function automatic logic pat(input logic [1:0] md, input int ph);
    case (md)
      2'd0:    return 1'b1;
      2'd1:    return ph < 2;
      2'd2:    return (ph % 2) == 0;
      default: return ph == 0;
    endcase
  endfunction

  task automatic m_grant(input int who);
    m_run   = 1'b1;
    m_owner = who;
    m_start = n;
    m_ptr   = who;
    m_mode  = 2'(mode >> (2 * who));
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 1'b0;
      m_ptr = NREQ - 1;
      n     = 0;
    end else begin
      n++;
      if (m_run && !req[m_owner[1:0]]) begin
        m_run = 1'b0;
      end else if (m_run && (n - m_start) == 4 * TD) begin
        w = pick(req, m_ptr);
        if (w < 0) m_run = 1'b0;
        else m_grant(w);
      end else if (!m_run && req != 4'b0) begin
        m_grant(pick(req, m_ptr));
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] eg;
    logic       el;
    if (chk_en) begin
      eg = m_run ? 4'(1 << m_owner) : 4'b0;
      el = m_run ? pat(m_mode, (n - m_start) / TD) : 1'b0;
      check("model_gnt", 32'(gnt), 32'(eg));
      check("model_led", 32'(led), 32'(el));
      check("model_busy", 32'(busy), 32'(m_run));
    end
  end

  initial begin
    // Reset state
    step(3);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_led", 32'(led), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Single requester, slow pattern 1,1,0,0 per window
    req  = 4'b0001;
    mode = 8'b0000_0001;
    step(1);
    check("r027_gnt", 32'(gnt), 32'h1);
    check("r027_busy", 32'(busy), 32'h1);
    check("r027_led_p0", 32'(led), 32'h1);
    step(TD);
    check("r027_led_p1", 32'(led), 32'h1);
    step(TD);
    check("r027_led_p2", 32'(led), 32'h0);
    step(TD);
    check("r027_led_p3", 32'(led), 32'h0);
    step(TD);
    check("r027_led_w1p0", 32'(led), 32'h1);
    check("r027_gnt_w1", 32'(gnt), 32'h1);

    // Owner drops at phase 1 while req2 waits
    step(TD);
    req = 4'b0100;
    step(1);
    check("r029_gnt_drop", 32'(gnt), 32'h0);
    check("r029_led_drop", 32'(led), 32'h0);
    check("r029_busy_drop", 32'(busy), 32'h0);
    step(1);
    check("r029_gnt2", 32'(gnt), 32'h4);
    check("r029_led2", 32'(led), 32'h1);

    // Mode change mid-window is ignored until the next grant
    req = 4'b0000;
    step(2);
    mode = 8'b0000_0011;
    req  = 4'b0001;
    step(1);
    check("r030_hb_p0", 32'(led), 32'h1);
    step(TD);
    check("r030_hb_p1", 32'(led), 32'h0);
    mode = 8'b0000_0000;
    step(TD);
    check("r030_hb_p2", 32'(led), 32'h0);
    step(TD);
    check("r030_hb_p3", 32'(led), 32'h0);
    step(TD);
    check("r030_solid_p0", 32'(led), 32'h1);
    step(TD);
    check("r030_solid_p1", 32'(led), 32'h1);

    // Asynchronous reset mid-window
    rst_n = 1'b0;
    #1;
    check("r031_gnt", 32'(gnt), 32'h0);
    check("r031_led", 32'(led), 32'h0);
    check("r031_busy", 32'(busy), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(1);
    check("r031_regnt", 32'(gnt), 32'h1);
    step(4 * TD - 1);
    check("r031_full_win", 32'(busy), 32'h1);
    step(1);
    check("r031_next_win", 32'(gnt), 32'h1);

    // Two requesters across windows
    req = 4'b0110;
    step(1);
    check("r028_idle", 32'(gnt), 32'h0);
    step(1);
    check("r028_w0", 32'(gnt), 32'h2);
    step(4 * TD);
`ifdef LED_ARB_ROUND_ROBIN_EN
    check("r028_w1", 32'(gnt), 32'h4);
`else
    check("r028_w1", 32'(gnt), 32'h2);
`endif
    step(4 * TD);
    check("r028_w2", 32'(gnt), 32'h2);

    // Drop coincident with the window-end tick
    req = 4'b0000;
    step(2);
    req = 4'b0001;
    step(1);
    check("r032_gnt0", 32'(gnt), 32'h1);
    step(4 * TD - 1);
    req = 4'b0010;
    step(1);
    check("r032_idle_gnt", 32'(gnt), 32'h0);
    check("r032_idle_busy", 32'(busy), 32'h0);
    step(1);
    check("r032_gnt1", 32'(gnt), 32'h2);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 23) == 0) req = 4'($urandom);
      if ($urandom_range(0, 7) == 0) mode = 8'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
      end
      step(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_arbiter.md
LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, legal range 2..8.
REQ-002 Parameter TICK_DIV, default 10000000: clk cycles per pattern tick, legal range 2..2^32-1.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1: asynchronous reset, active-low.
REQ-005 Port req  input  NREQ: level request per requester.
REQ-006 Port mode  input  2*NREQ: 2-bit pattern code per requester; requester i uses bits [2i+1:2i].
REQ-007 Port led  output  1: registered LED drive.
REQ-008 Port gnt  output  NREQ: registered grant, one-hot or zero.
REQ-009 Port busy  output  1: registered; high while in RUN.

Function
REQ-010 Tick divider SHALL be a 32-bit counter 0..TICK_DIV-1; tick SHALL pulse for one cycle at TICK_DIV-1, then the counter wraps to 0.
REQ-011 Divider SHALL be cleared to 0 on IDLE->RUN and on every re-arbitration, so each window starts with a full tick period.
REQ-012 FSM states SHALL be IDLE and RUN only.
REQ-013 In IDLE with any req bit high, the next edge SHALL enter RUN, assert the winner's gnt bit, set phase=0 and busy=1 (one-cycle req->gnt latency).
REQ-014 The winner's mode SHALL be latched at grant; mode changes during a window SHALL be ignored.
REQ-015 The 2-bit phase SHALL advance on each tick in RUN and wrap 3->0; ticks 0..3 form one window.
REQ-016 led SHALL be a function of latched mode and the phase being loaded, updating on the same edge as phase: 00 solid=1; 01 slow=~phase[1]; 10 fast=~phase[0]; 11 heartbeat=(phase==0).
REQ-017 Re-arbitration SHALL occur only on the tick that wraps phase 3->0: winner granted (may be the same requester); if no req, go IDLE.
REQ-018 If the granted requester drops req in RUN, the next edge SHALL clear gnt, led and busy and enter IDLE; re-arbitration follows one cycle later per REQ-013.
REQ-019 If the drop coincides with a window-end tick, REQ-018 SHALL take precedence.
REQ-020 Requests from non-granted requesters SHALL never pre-empt a running window.

Reset
REQ-021 rst_n low SHALL asynchronously force led=0, gnt=0, busy=0, state=IDLE, phase=0, divider=0 and round-robin pointer=NREQ-1.
REQ-022 Reset asserted mid-window SHALL abort the window; after release the block SHALL behave as from power-up.

Configuration
REQ-023 Macro LED_ARB_ROUND_ROBIN_EN defined: the winner SHALL be the first requesting index searching upward, with wrap, from last-granted+1; the pointer updates on every grant.
REQ-024 Macro LED_ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins; no pointer register SHALL exist.

Structure
REQ-025 Shared package led_pkg SHALL hold the mode typedef (SOLID, SLOW, FAST, HEARTBEAT), the FSM state typedef and the TICK_DIV default constant.
REQ-026 The tick divider SHALL be a sub-module led_tick_gen with inputs clk, rst_n and clr, and output tick.

Verification (TICK_DIV=4)
REQ-027 Reset then req=4'b0001, mode0=01 -> gnt=0001 one cycle later; led 1,1,0,0 across ticks 0..3 of each window.
REQ-028 req=4'b0110 fixed priority -> gnt=0010 for every window; with LED_ARB_ROUND_ROBIN_EN, gnt alternates 0010,0100 per window.
REQ-029 Granted req0 drops at phase 1 -> next cycle gnt=0, led=0, busy=0; req2 high -> gnt=0100 one cycle later.
REQ-030 mode0 changed 11->00 mid-window -> heartbeat (1,0,0,0) holds until window end; solid 1 from the next window.
REQ-031 rst_n pulsed low mid-window -> led, gnt and busy immediately 0; a full window is re-run from the first grant after release.
REQ-032 req0 drop coincident with window-end tick while req1 high -> IDLE for one cycle, then gnt=0010.
